// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_arbiter
// Purpose  : Round-robin sharing of the single 32-bit register-file read port
//            among NUM_REQ requesters, with a fixed 2-cycle response latency.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [5*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 stall,
    output logic [4:0]           mux_sel,
    input  logic [31:0]          mux_data,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]     r_rr_ptr;
    logic [4:0]         r_mux_sel;
    logic               r_s1_valid;
    logic [IDW-1:0]     r_s1_id;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [31:0]        r_rsp_data;

    logic               w_found;
    logic [IDW-1:0]     w_grant_id;
    logic [NUM_REQ-1:0] w_grant;
    logic [4:0]         w_grant_addr;
    logic [NUM_REQ-1:0] w_s1_onehot;
    logic [31:0]        w_rd_data;

    function automatic logic [IDW-1:0] f_wrap(input int v);
        f_wrap = IDW'(v % NUM_REQ);
    endfunction

    // Scan starts at the round-robin pointer; the first valid requester wins.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        if (!stall && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_found && req_valid[f_wrap(int'(r_rr_ptr) + k)]) begin
                    w_found    = 1'b1;
                    w_grant_id = f_wrap(int'(r_rr_ptr) + k);
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_s1_onehot          = '0;
        w_s1_onehot[r_s1_id] = 1'b1;
    end

    assign w_grant_addr = req_addr[5*int'(w_grant_id) +: 5];
    assign w_rd_data    = (ZERO_REG0 && (r_mux_sel == 5'd0)) ? 32'h0 : mux_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_mux_sel   <= 5'd0;
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= 32'h0;
        end else begin
            r_s1_valid <= w_found;
            if (w_found) begin
                r_mux_sel <= w_grant_addr;
                r_s1_id   <= w_grant_id;
                r_rr_ptr  <= f_wrap(int'(w_grant_id) + 1);
            end
            // Mux output has had a full cycle to settle on the registered select.
            if (r_s1_valid) begin
                r_rsp_valid <= w_s1_onehot;
                r_rsp_data  <= w_rd_data;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign req_ready = w_grant;
    assign mux_sel   = r_mux_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_s1_valid;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_arbiter
// Purpose  : Scoreboard bench for regfile_read_arbiter against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [5*N-1:0] req_addr;
    logic [N-1:0]  req_ready;
    logic          stall;
    logic [4:0]    mux_sel;
    logic [31:0]   mux_data;
    logic [N-1:0]  rsp_valid;
    logic [31:0]   rsp_data;
    logic          busy;

    logic          force_ones = 1'b0;
    logic          mon_en     = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    int          m_rr   = 0;
    logic [4:0]  m_sel  = 5'd0;
    logic        m_busy = 1'b0;

    regfile_read_arbiter #(.NUM_REQ(N), .ZERO_REG0(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .stall     (stall),
        .mux_sel   (mux_sel),
        .mux_data  (mux_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Register-file read mux stand-in: recognisable data per register index.
    assign mux_data = force_ones ? 32'hFFFF_FFFF : {16'hA5A5, 11'd0, mux_sel};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every response pulse must match the oldest outstanding read.
    always @(negedge clock) begin
        if (mon_en) begin
            if (rsp_valid != '0) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: actual valid=%b data=%h required no response", rsp_valid, rsp_data);
                end else begin
                    exp_t e;
                    logic [N-1:0] oh;
                    e  = q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    if (rsp_valid !== oh || rsp_data !== e.data || cyc != e.due) begin
                        n_fail++;
                        $display("FAIL rsp: actual valid=%b data=%h cyc=%0d required valid=%b data=%h cyc=%0d",
                                 rsp_valid, rsp_data, cyc, oh, e.data, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                n_vec++;
                n_fail++;
                $display("FAIL rsp_missing: actual valid=%b required id=%0d data=%h at cyc=%0d",
                         rsp_valid, q[0].id, q[0].data, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    function automatic int exp_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // One cycle: drive inputs, check combinational/registered outputs, update model.
    task automatic step(input logic [N-1:0] v, input logic [5*N-1:0] a,
                        input logic s, input logic r);
        int          w;
        logic [N-1:0] exp_rdy;
        logic [4:0]  addr;
        exp_t        e;
        req_valid = v;
        req_addr  = a;
        stall     = s;
        reset     = r;
        @(negedge clock);
        w       = (s || r) ? -1 : exp_winner(v, m_rr);
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("mux_sel",   32'(mux_sel),   32'(m_sel));
        check("busy",      32'(busy),      32'(m_busy));
        if (r) begin
            while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
            m_rr   = 0;
            m_sel  = 5'd0;
            m_busy = 1'b0;
        end else if (w >= 0) begin
            addr   = a[5*w +: 5];
            e.id   = w;
            e.data = (addr == 5'd0) ? 32'h0 : (force_ones ? 32'hFFFF_FFFF : {16'hA5A5, 11'd0, addr});
            e.due  = cyc + 2;
            q.push_back(e);
            m_rr   = (w + 1) % N;
            m_sel  = addr;
            m_busy = 1'b1;
        end else begin
            m_busy = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [5*N-1:0] a;
        req_valid = '0;
        req_addr  = '0;
        stall     = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset then idle
        for (int i = 0; i < 10; i++) step('0, '0, 1'b0, 1'b0);
        check("idle_rsp_valid", 32'(rsp_valid), 32'h0);

        // Single read of register 7 by requester 0
        step(4'b0001, 20'd7, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);

        // Round-robin with all requesters valid, addr_i = i+1
        step('0, '0, 1'b0, 1'b1);
        a = {5'd4, 5'd3, 5'd2, 5'd1};
        for (int i = 0; i < 8; i++) step(4'b1111, a, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);

        // Register 0 reads as zero even when the mux drives all ones
        force_ones = 1'b1;
        step(4'b0100, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        force_ones = 1'b0;

        // Stall with a read already in flight
        a = {5'd0, 5'd0, 5'd12, 5'd11};
        step(4'b0011, a, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0011, a, 1'b1, 1'b0);
        step(4'b0011, a, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);

        // Reset immediately after accepting a read
        step(4'b0001, 20'd9, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b0);
        step(4'b1000, {5'd5, 15'd0}, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0]   rv;
            logic [5*N-1:0] ra;
            rv = N'($urandom_range(0, (1 << N) - 1));
            ra = 20'($urandom);
            step(rv, ra, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 4; i++) step('0, '0, 1'b0, 1'b0);

        check("queue_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
